// File: rtl/riscv_privileged_pkg.sv
// Shared types for the Zicsr access path between execute and exception_handler.
// Holds the CSR bus command encoding, the decoded operation and the access sequencer states.
package riscv_privileged_pkg;

  typedef enum logic [1:0] {
    NO_COMMAND = 2'b00,
    READ_ONLY  = 2'b01,
    WRITE_ONLY = 2'b10,
    READ_WRITE = 2'b11
  } csr_command_t;

  typedef enum logic [1:0] {
    CSR_RW      = 2'b00,
    CSR_RS      = 2'b01,
    CSR_RC      = 2'b10,
    CSR_ILLEGAL = 2'b11
  } csr_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } csr_access_state_t;

  // funct3 bit 2 selects the zero-extended immediate (zimm) form
  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

endpackage

// File: rtl/csr_access_unit_alu.sv
// Combinational Zicsr decode: operation, source operand, new CSR value and
// whether the instruction reads and/or writes the CSR.
module csr_alu
  import riscv_privileged_pkg::*;
#(
  parameter int unsigned MXLEN = 64
) (
  input  logic [2:0]       funct3_i,
  input  logic [4:0]       rd_i,
  input  logic [4:0]       rs1_idx_i,
  input  logic [MXLEN-1:0] rs1_data_i,
  input  logic [MXLEN-1:0] old_i,
  output csr_op_t          op_o,
  output logic [MXLEN-1:0] new_value_o,
  output logic             do_read_o,
  output logic             do_write_o
);

  logic [MXLEN-1:0] src;

  assign src = funct3_i[2] ? {{(MXLEN-5){1'b0}}, rs1_idx_i} : rs1_data_i;

  always_comb begin
    op_o = CSR_ILLEGAL;
    case (funct3_i)
      F3_CSRRW, F3_CSRRWI: op_o = CSR_RW;
      F3_CSRRS, F3_CSRRSI: op_o = CSR_RS;
      F3_CSRRC, F3_CSRRCI: op_o = CSR_RC;
      default:             op_o = CSR_ILLEGAL;
    endcase
  end

  always_comb begin
    new_value_o = src;
    case (op_o)
      CSR_RS:  new_value_o = old_i | src;
      CSR_RC:  new_value_o = old_i & ~src;
      default: new_value_o = src;
    endcase
  end

  // CSRRW to x0 must not read (no read side effects); set/clear with rs1/zimm of 0 must not write
  assign do_read_o  = !((op_o == CSR_RW) && (rd_i == 5'd0));
  assign do_write_o = (op_o == CSR_RW) || (rs1_idx_i != 5'd0);

endmodule

// File: rtl/csr_access_unit.sv
// Sequences one Zicsr instruction as a read phase then an optional write phase on the
// CSR command bus, and returns the old value plus an illegal flag to writeback.
module csr_access_unit
  import riscv_privileged_pkg::*;
#(
  parameter int unsigned MXLEN          = 64,
  parameter int unsigned CSR_ADDR_WIDTH = 12
) (
  input  logic                      clock_i,
  input  logic                      reset_ni,
  input  logic                      flush_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [2:0]                req_funct3_i,
  input  logic [4:0]                req_rd_i,
  input  logic [4:0]                req_rs1_idx_i,
  input  logic [MXLEN-1:0]          req_rs1_data_i,
  input  logic [CSR_ADDR_WIDTH-1:0] req_csr_address_i,
  output logic [CSR_ADDR_WIDTH-1:0] csr_address_o,
  output csr_command_t              csr_command_o,
  output logic [MXLEN-1:0]          csr_write_data_o,
  input  logic [MXLEN-1:0]          csr_read_data_i,
  input  logic                      csr_read_data_valid_i,
  output logic                      resp_valid_o,
  input  logic                      resp_ready_i,
  output logic [4:0]                resp_rd_o,
  output logic [MXLEN-1:0]          resp_data_o,
  output logic                      resp_rd_we_o,
  output logic                      resp_illegal_o
);

  csr_access_state_t         state_q, state_d;
  logic [2:0]                funct3_q, funct3_d;
  logic [4:0]                rd_q, rd_d;
  logic [4:0]                rs1_idx_q, rs1_idx_d;
  logic [MXLEN-1:0]          rs1_data_q, rs1_data_d;
  logic [CSR_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [MXLEN-1:0]          old_q, old_d;
  logic                      illegal_q, illegal_d;

  csr_op_t          op;
  logic [MXLEN-1:0] new_value;
  logic             do_read;
  logic             do_write;
  logic             read_only_csr;
  logic             illegal_now;

  csr_alu #(
    .MXLEN(MXLEN)
  ) u_alu (
    .funct3_i    (funct3_q),
    .rd_i        (rd_q),
    .rs1_idx_i   (rs1_idx_q),
    .rs1_data_i  (rs1_data_q),
    .old_i       (old_q),
    .op_o        (op),
    .new_value_o (new_value),
    .do_read_o   (do_read),
    .do_write_o  (do_write)
  );

  // Address bits [11:10] == 2'b11 mark the read-only CSR space
  assign read_only_csr = (addr_q[CSR_ADDR_WIDTH-1 -: 2] == 2'b11);
  assign illegal_now   = (op == CSR_ILLEGAL) || !csr_read_data_valid_i ||
                         (do_write && read_only_csr);

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      state_q    <= IDLE;
      funct3_q   <= 3'd0;
      rd_q       <= 5'd0;
      rs1_idx_q  <= 5'd0;
      rs1_data_q <= '0;
      addr_q     <= '0;
      old_q      <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      funct3_q   <= funct3_d;
      rd_q       <= rd_d;
      rs1_idx_q  <= rs1_idx_d;
      rs1_data_q <= rs1_data_d;
      addr_q     <= addr_d;
      old_q      <= old_d;
      illegal_q  <= illegal_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    funct3_d         = funct3_q;
    rd_d             = rd_q;
    rs1_idx_d        = rs1_idx_q;
    rs1_data_d       = rs1_data_q;
    addr_d           = addr_q;
    old_d            = old_q;
    illegal_d        = illegal_q;
    req_ready_o      = 1'b0;
    csr_address_o    = '0;
    csr_command_o    = NO_COMMAND;
    csr_write_data_o = '0;
    resp_valid_o     = 1'b0;
    resp_rd_o        = 5'd0;
    resp_data_o      = '0;
    resp_rd_we_o     = 1'b0;
    resp_illegal_o   = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i && !flush_i) begin
          funct3_d   = req_funct3_i;
          rd_d       = req_rd_i;
          rs1_idx_d  = req_rs1_idx_i;
          rs1_data_d = req_rs1_data_i;
          addr_d     = req_csr_address_i;
          state_d    = READ;
        end
      end

      READ: begin
        csr_address_o = addr_q;
        csr_command_o = do_read ? READ_ONLY : NO_COMMAND;
        old_d         = csr_read_data_i;
        illegal_d     = illegal_now;
        if (flush_i) begin
          state_d = IDLE;
        end else if (do_write && !illegal_now) begin
          state_d = WRITE;
        end else begin
          state_d = RESP;
        end
      end

      WRITE: begin
        // The write commits this cycle even under flush; only the response is dropped
        csr_address_o    = addr_q;
        csr_command_o    = WRITE_ONLY;
        csr_write_data_o = new_value;
        state_d          = flush_i ? IDLE : RESP;
      end

      RESP: begin
        resp_valid_o   = !flush_i;
        resp_rd_o      = rd_q;
        resp_illegal_o = illegal_q;
        resp_data_o    = (do_read && !illegal_q) ? old_q : '0;
        resp_rd_we_o   = !illegal_q && (rd_q != 5'd0);
        if (flush_i || resp_ready_i) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench: expected bus commands and responses go into scoreboard queues at
// acceptance; a negedge monitor pops and compares whatever the DUT presents.
module tb_csr_access_unit;
  import riscv_privileged_pkg::*;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic        flush_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  req_funct3_i;
  logic [4:0]  req_rd_i;
  logic [4:0]  req_rs1_idx_i;
  logic [63:0] req_rs1_data_i;
  logic [11:0] req_csr_address_i;
  logic [11:0] csr_address_o;
  csr_command_t csr_command_o;
  logic [63:0] csr_write_data_o;
  logic [63:0] csr_read_data_i;
  logic        csr_read_data_valid_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [4:0]  resp_rd_o;
  logic [63:0] resp_data_o;
  logic        resp_rd_we_o;
  logic        resp_illegal_o;

  always #5 clk = ~clk;

  csr_access_unit #(.MXLEN(64), .CSR_ADDR_WIDTH(12)) dut (
    .clock_i               (clk),
    .reset_ni              (reset_ni),
    .flush_i               (flush_i),
    .req_valid_i           (req_valid_i),
    .req_ready_o           (req_ready_o),
    .req_funct3_i          (req_funct3_i),
    .req_rd_i              (req_rd_i),
    .req_rs1_idx_i         (req_rs1_idx_i),
    .req_rs1_data_i        (req_rs1_data_i),
    .req_csr_address_i     (req_csr_address_i),
    .csr_address_o         (csr_address_o),
    .csr_command_o         (csr_command_o),
    .csr_write_data_o      (csr_write_data_o),
    .csr_read_data_i       (csr_read_data_i),
    .csr_read_data_valid_i (csr_read_data_valid_i),
    .resp_valid_o          (resp_valid_o),
    .resp_ready_i          (resp_ready_i),
    .resp_rd_o             (resp_rd_o),
    .resp_data_o           (resp_data_o),
    .resp_rd_we_o          (resp_rd_we_o),
    .resp_illegal_o        (resp_illegal_o)
  );

  typedef struct {
    csr_command_t cmd;
    logic [11:0]  addr;
    logic [63:0]  data;
    int           cyc;
  } cmd_exp_t;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    logic        we;
    logic        ill;
    int          cyc;
  } rsp_exp_t;

  cmd_exp_t cmd_q[$];
  rsp_exp_t rsp_q[$];
  cmd_exp_t ce;
  rsp_exp_t re;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   first_cyc = 0;
  int   acc;
  logic mon_en = 1'b0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input csr_command_t c, input logic [11:0] a, input logic [63:0] d, input int cy);
    cmd_q.push_back('{cmd: c, addr: a, data: d, cyc: cy});
  endtask

  task automatic push_rsp(input logic [4:0] rd, input logic [63:0] d, input logic we, input logic ill, input int cy);
    rsp_q.push_back('{rd: rd, data: d, we: we, ill: ill, cyc: cy});
  endtask

  // Monitor: cyc+1 at the negedge is the cycle number ending at the next rising edge
  always @(negedge clk) begin
    if (mon_en) begin
      if (csr_command_o != NO_COMMAND) begin
        if (cmd_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_cmd: got cmd %0d addr 0x%0h data 0x%0h at cycle %0d, expected none",
                   csr_command_o, csr_address_o, csr_write_data_o, cyc + 1);
        end else begin
          ce = cmd_q.pop_front();
          chk("cmd_kind", 64'(csr_command_o), 64'(ce.cmd));
          chk("cmd_addr", 64'(csr_address_o), 64'(ce.addr));
          chk("cmd_wdata", csr_write_data_o, ce.data);
          chk("cmd_cycle", 64'(cyc + 1), 64'(ce.cyc));
        end
      end
      if (resp_valid_o && !prev_valid) first_cyc = cyc + 1;
      prev_valid = resp_valid_o;
      if (resp_valid_o && resp_ready_i) begin
        if (rsp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_resp: got rd %0d data 0x%0h at cycle %0d, expected none",
                   resp_rd_o, resp_data_o, cyc + 1);
        end else begin
          re = rsp_q.pop_front();
          chk("resp_rd", 64'(resp_rd_o), 64'(re.rd));
          chk("resp_data", resp_data_o, re.data);
          chk("resp_we", 64'(resp_rd_we_o), 64'(re.we));
          chk("resp_illegal", 64'(resp_illegal_o), 64'(re.ill));
          chk("resp_first_cycle", 64'(first_cyc), 64'(re.cyc));
        end
      end
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic issue(input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [63:0] d, input logic [11:0] a, output int acc_cyc);
    int w;
    @(negedge clk);
    req_funct3_i      = f3;
    req_rd_i          = rd;
    req_rs1_idx_i     = rs1;
    req_rs1_data_i    = d;
    req_csr_address_i = a;
    req_valid_i       = 1'b1;
    w = 0;
    while (!req_ready_o && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready_o) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: req_ready_o stayed 0, expected 1");
    end
    @(posedge clk); #1;
    acc_cyc     = cyc;
    req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((cmd_q.size() != 0 || rsp_q.size() != 0 || !req_ready_o) && w < 30) begin
      @(posedge clk); #2;
      w++;
    end
    n_vec++;
    if (cmd_q.size() != 0 || rsp_q.size() != 0 || !req_ready_o) begin
      n_err++;
      $display("FAIL drain_timeout: %0d cmds and %0d resps pending, req_ready_o=%0b; expected none pending and ready",
               cmd_q.size(), rsp_q.size(), req_ready_o);
    end
  endtask

  initial begin
    reset_ni = 1'b0; flush_i = 1'b0; req_valid_i = 1'b0; resp_ready_i = 1'b1;
    req_funct3_i = 3'd0; req_rd_i = 5'd0; req_rs1_idx_i = 5'd0; req_rs1_data_i = '0;
    req_csr_address_i = '0; csr_read_data_i = '0; csr_read_data_valid_i = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready_o), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
    chk("rst_resp_rd", 64'(resp_rd_o), 64'd0);
    chk("rst_resp_data", resp_data_o, 64'd0);
    chk("rst_resp_we", 64'(resp_rd_we_o), 64'd0);
    chk("rst_resp_ill", 64'(resp_illegal_o), 64'd0);
    chk("rst_cmd", 64'(csr_command_o), 64'(NO_COMMAND));
    chk("rst_addr", 64'(csr_address_o), 64'd0);
    chk("rst_wdata", csr_write_data_o, 64'd0);
    reset_ni = 1'b1;
    mon_en   = 1'b1;

    // CSRRW x5, mscratch, rs1=0xDEADBEEF, old 0
    csr_read_data_i = 64'h0;
    issue(3'b001, 5'd5, 5'd10, 64'hDEAD_BEEF, 12'h340, acc);
    push_cmd(READ_ONLY, 12'h340, 64'h0, acc + 1);
    push_cmd(WRITE_ONLY, 12'h340, 64'hDEAD_BEEF, acc + 2);
    push_rsp(5'd5, 64'h0, 1'b1, 1'b0, acc + 3);
    drain();

    // CSRRS x7, mscratch, rs1=0xF0, old 0x0F -> write 0xFF
    csr_read_data_i = 64'h0F;
    issue(3'b010, 5'd7, 5'd3, 64'hF0, 12'h340, acc);
    push_cmd(READ_ONLY, 12'h340, 64'h0, acc + 1);
    push_cmd(WRITE_ONLY, 12'h340, 64'hFF, acc + 2);
    push_rsp(5'd7, 64'h0F, 1'b1, 1'b0, acc + 3);
    drain();

    // CSRRW x0: no read phase command, write only, response data 0
    csr_read_data_i = 64'h77;
    issue(3'b001, 5'd0, 5'd4, 64'h55, 12'h340, acc);
    push_cmd(WRITE_ONLY, 12'h340, 64'h55, acc + 2);
    push_rsp(5'd0, 64'h0, 1'b0, 1'b0, acc + 3);
    drain();

    // CSRRS x0, mie, rs1 index 0: read only, no write
    csr_read_data_i = 64'h5;
    issue(3'b010, 5'd0, 5'd0, 64'hFFFF, 12'h304, acc);
    push_cmd(READ_ONLY, 12'h304, 64'h0, acc + 1);
    push_rsp(5'd0, 64'h5, 1'b0, 1'b0, acc + 2);
    drain();

    // CSRRCI x6, mstatus, zimm=8, old 0x88 -> write 0x80 (rs1 data ignored)
    csr_read_data_i = 64'h88;
    issue(3'b111, 5'd6, 5'd8, 64'hFFFF, 12'h300, acc);
    push_cmd(READ_ONLY, 12'h300, 64'h0, acc + 1);
    push_cmd(WRITE_ONLY, 12'h300, 64'h80, acc + 2);
    push_rsp(5'd6, 64'h88, 1'b1, 1'b0, acc + 3);
    drain();

    // CSRRW to nonexistent 0xFFF
    csr_read_data_i = 64'h99; csr_read_data_valid_i = 1'b0;
    issue(3'b001, 5'd1, 5'd2, 64'h1, 12'hFFF, acc);
    push_cmd(READ_ONLY, 12'hFFF, 64'h0, acc + 1);
    push_rsp(5'd1, 64'h0, 1'b0, 1'b1, acc + 2);
    drain();
    csr_read_data_valid_i = 1'b1;

    // funct3=100 is illegal
    csr_read_data_i = 64'h33;
    issue(3'b100, 5'd2, 5'd1, 64'h1, 12'h340, acc);
    push_cmd(READ_ONLY, 12'h340, 64'h0, acc + 1);
    push_rsp(5'd2, 64'h0, 1'b0, 1'b1, acc + 2);
    drain();

    // Write attempt to read-only cycle CSR is illegal; a pure read of it is legal
    csr_read_data_i = 64'h1000;
    issue(3'b010, 5'd3, 5'd1, 64'h1, 12'hC00, acc);
    push_cmd(READ_ONLY, 12'hC00, 64'h0, acc + 1);
    push_rsp(5'd3, 64'h0, 1'b0, 1'b1, acc + 2);
    drain();
    issue(3'b010, 5'd3, 5'd0, 64'h1, 12'hC00, acc);
    push_cmd(READ_ONLY, 12'hC00, 64'h0, acc + 1);
    push_rsp(5'd3, 64'h1000, 1'b1, 1'b0, acc + 3 - 1);
    drain();

    // Backpressure: CSRRWI x5 with resp_ready low for 5 cycles
    csr_read_data_i = 64'hABC; resp_ready_i = 1'b0;
    issue(3'b101, 5'd5, 5'd31, 64'h0, 12'h340, acc);
    push_cmd(READ_ONLY, 12'h340, 64'h0, acc + 1);
    push_cmd(WRITE_ONLY, 12'h340, 64'h1F, acc + 2);
    push_rsp(5'd5, 64'hABC, 1'b1, 1'b0, acc + 3);
    repeat (2) begin @(posedge clk); #1; end
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 64'(resp_valid_o), 64'd1);
      chk("hold_data", resp_data_o, 64'hABC);
      chk("hold_rd", 64'(resp_rd_o), 64'd5);
      chk("hold_req_ready", 64'(req_ready_o), 64'd0);
      @(posedge clk); #1;
    end
    resp_ready_i = 1'b1;
    drain();

    // Flush in READ: no write, no response, ready again next cycle
    csr_read_data_i = 64'h0;
    issue(3'b001, 5'd5, 5'd1, 64'h1, 12'h340, acc);
    push_cmd(READ_ONLY, 12'h340, 64'h0, acc + 1);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush_read_ready", 64'(req_ready_o), 64'd1);
    chk("flush_read_no_resp", 64'(resp_valid_o), 64'd0);
    drain();

    // Flush in WRITE: write still commits, no response
    issue(3'b001, 5'd5, 5'd1, 64'h2, 12'h340, acc);
    push_cmd(READ_ONLY, 12'h340, 64'h0, acc + 1);
    push_cmd(WRITE_ONLY, 12'h340, 64'h2, acc + 2);
    @(posedge clk); #1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush_write_ready", 64'(req_ready_o), 64'd1);
    chk("flush_write_no_resp", 64'(resp_valid_o), 64'd0);
    drain();

    // Flush in IDLE blocks acceptance
    @(negedge clk);
    req_funct3_i = 3'b001; req_rd_i = 5'd5; req_rs1_idx_i = 5'd1;
    req_csr_address_i = 12'h340; req_valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk); #1;
    chk("flush_idle_ready", 64'(req_ready_o), 64'd1);
    req_valid_i = 1'b0; flush_i = 1'b0;
    drain();

    // Reset during WRITE drops the access
    issue(3'b001, 5'd5, 5'd1, 64'h3, 12'h340, acc);
    push_cmd(READ_ONLY, 12'h340, 64'h0, acc + 1);
    push_cmd(WRITE_ONLY, 12'h340, 64'h3, acc + 2);
    @(posedge clk); #1;
    reset_ni = 1'b0;
    @(posedge clk); #1;
    chk("rstw_cmd", 64'(csr_command_o), 64'(NO_COMMAND));
    chk("rstw_addr", 64'(csr_address_o), 64'd0);
    chk("rstw_wdata", csr_write_data_o, 64'd0);
    chk("rstw_resp_valid", 64'(resp_valid_o), 64'd0);
    chk("rstw_req_ready", 64'(req_ready_o), 64'd1);
    reset_ni = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    drain();

    // Normal access after reset
    csr_read_data_i = 64'h1234;
    issue(3'b011, 5'd9, 5'd1, 64'h4, 12'h340, acc);
    push_cmd(READ_ONLY, 12'h340, 64'h0, acc + 1);
    push_cmd(WRITE_ONLY, 12'h340, 64'h1230, acc + 2);
    push_rsp(5'd9, 64'h1234, 1'b1, 1'b0, acc + 3);
    drain();

    chk("final_cmd_queue_empty", 64'(cmd_q.size()), 64'd0);
    chk("final_resp_queue_empty", 64'(rsp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/csr_access_unit.md
Name: csr_access_unit

Overview:
- Sits between the Lagarto Hun execute stage and exception_handler.
- Accepts one decoded Zicsr instruction at a time and sequences it as a read phase then a write phase on the CSR command bus.
- Performs the CSRRW/S/C read-modify-write and returns the old CSR value and an illegal-instruction flag to the writeback path.

Parameters:
- MXLEN, 64, CSR data width; must equal MXLEN in riscv_pkg.
- CSR_ADDR_WIDTH, 12, CSR address width.

Ports:
- clock_i  in  1  clock; all state updates on the rising edge.
- reset_ni  in  1  reset; synchronous, active-low.
- flush_i  in  1  pipeline flush; aborts the in-flight access.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready; high only in IDLE.
- req_funct3_i  in  3  Zicsr funct3.
- req_rd_i  in  5  destination register index.
- req_rs1_idx_i  in  5  rs1 index; also the zimm field.
- req_rs1_data_i  in  MXLEN  rs1 value.
- req_csr_address_i  in  CSR_ADDR_WIDTH  target CSR.
- csr_address_o  out  CSR_ADDR_WIDTH  to exception_handler.
- csr_command_o  out  csr_command_t  to exception_handler.
- csr_write_data_o  out  MXLEN  to exception_handler.
- csr_read_data_i  in  MXLEN  from exception_handler; combinational.
- csr_read_data_valid_i  in  1  from exception_handler; CSR exists and is accessible.
- resp_valid_o  out  1  response valid.
- resp_ready_i  in  1  response accepted.
- resp_rd_o  out  5  destination register.
- resp_data_o  out  MXLEN  old CSR value; zero when not read.
- resp_rd_we_o  out  1  register-file write enable.
- resp_illegal_o  out  1  raise illegal-instruction exception.

Behaviour:
- Reset (reset_ni low at a rising edge): state IDLE.
  - req_ready_o=1 in IDLE.
  - resp_valid_o=0; resp_* data fields 0.
  - csr_command_o=NO_COMMAND; csr_address_o=0; csr_write_data_o=0.
  - Reset mid-access drops the access; no write is issued afterwards.
- Handshake:
  - Request accepted on req_valid_i && req_ready_o; all request fields are latched.
  - Response is held stable while resp_valid_o && !resp_ready_i.
  - Response completes on resp_valid_o && resp_ready_i; the unit returns to IDLE.
  - No new request is accepted in the completion cycle.
- Operand: src = zero-extended req_rs1_idx_i when funct3[2]=1, else req_rs1_data_i.
- Operation by funct3:
  - 001/101 (RW): new = src.
  - 010/110 (RS): new = old | src.
  - 011/111 (RC): new = old & ~src.
  - 000/100: illegal.
- Read/write decision:
  - do_read = !(RW && rd==0).
  - do_write = RW || (rs1_idx != 0).
- FSM: IDLE -> READ -> WRITE (only if do_write && legal) -> RESP -> IDLE.
- READ state (one cycle):
  - Drive csr_address_o; csr_command_o = READ_ONLY if do_read, else NO_COMMAND.
  - Sample csr_read_data_i into old, and csr_read_data_valid_i.
- Illegal if any of:
  - funct3 is 000 or 100;
  - sampled csr_read_data_valid_i == 0;
  - do_write && address[11:10]==2'b11 (read-only CSR).
  - On illegal: skip WRITE, go to RESP with resp_illegal_o=1, resp_rd_we_o=0, resp_data_o=0.
- WRITE state (one cycle): csr_command_o=WRITE_ONLY, csr_write_data_o=new, csr_address_o held.
- Outside READ and WRITE: csr_command_o=NO_COMMAND.
- RESP:
  - resp_data_o = old if do_read, else 0.
  - resp_rd_we_o = legal && rd != 0.
  - resp_rd_o = latched rd.
- Latency (request accepted at edge N):
  - READ in cycle N+1; WRITE in N+2; resp_valid_o from N+3.
  - Without write, or when illegal: resp_valid_o from N+2.
- Flush:
  - flush_i in READ or RESP: next state IDLE; no write; no response.
  - flush_i in WRITE: the write still commits that cycle; next state IDLE; no response.
  - flush_i in IDLE: the request is not accepted.
  - flush_i wins over simultaneous resp_ready_i.

Decomposition:
- riscv_privileged_pkg:
  - Add NO_COMMAND to csr_command_t.
  - Add csr_op_t enum (CSR_RW, CSR_RS, CSR_RC, CSR_ILLEGAL).
  - Add funct3 constants.
  - Add csr_access_state_t (IDLE, READ, WRITE, RESP).
- Sub-module csr_alu: combinational decode of funct3 to csr_op_t, src mux, new-value computation, do_read/do_write.

Test Plan:
- CSRRW x5, mscratch (0x340), rs1=0xDEADBEEF: READ_ONLY at N+1; WRITE_ONLY 0xDEADBEEF at N+2; resp at N+3 with data=old value 0, rd_we=1.
- CSRRS x0, mie (0x304), rs1=x0 (not zero register index is 0): no WRITE cycle; resp at N+2 with rd_we=0, illegal=0.
- CSRRCI x6, mstatus, zimm=0x8, old=0x88: write data 0x80; resp data 0x88.
- CSRRW to unsupported 0xFFF (read_data_valid=0): no WRITE issued; resp at N+2 with illegal=1, rd_we=0.
- funct3=100: illegal=1 with no WRITE issued.
- resp_ready_i low 5 cycles: response held stable and req_ready_o stays 0.
- flush_i in READ: no WRITE_ONLY ever seen and no resp_valid_o; req_ready_o=1 the next cycle.
- reset_ni low during WRITE: all outputs zero next edge; state IDLE.
